mult_scheduler: RTL and testbench

Round-robin scheduler that shares one `multiplier` instance (W-bit operands, M-cycle latency) among N requesters. Each cycle it accepts at most one operand pair and drives the multiplier operand ports. A tag pipeline matched to the multiplier latency carries the requester ID, so each product returns to its owner. A per-requester credit limit bounds in-flight work, because responses have no backpressure. The block sits between the client ports and the multiplier instance in the parent.

---
 rtl/mult_scheduler_pkg.sv | 12 +
 rtl/mult_scheduler_if.sv | 18 +
 rtl/mult_scheduler_rr_arbiter.sv | 23 ++
 rtl/mult_scheduler.sv | 74 +++++++
 tb/tb_mult_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_scheduler_pkg.sv
// mult_sched_pkg: width helpers and the round-robin index function shared by the multiplier scheduler.
package mult_sched_pkg;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction
  function automatic int rr_idx(input int p, input int k, input int n);
    return (p + k) % n;
  endfunction
endpackage

// File: rtl/mult_scheduler_if.sv
// mult_scheduler_if: client-side request/response bundle of the multiplier scheduler.
interface mult_scheduler_if
  import mult_sched_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int IDW = id_w(N);
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [2*W-1:0]        resp_product;
  modport master (output req_valid, req_a, req_b, input req_ready, resp_valid, resp_id, resp_product);
  modport slave  (input req_valid, req_a, req_b, output req_ready, resp_valid, resp_id, resp_product);
endinterface

// File: rtl/mult_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over elig, searching upward from ptr.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = id_w(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic           grant_any,
  output logic [IDW-1:0] grant_idx
);
  // Walk from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (elig[IDW'(rr_idx(int'(ptr), k, N))]) grant_idx = IDW'(rr_idx(int'(ptr), k, N));
    grant_any = |elig;
    grant = '0;
    grant[grant_idx] = grant_any;
  end
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: shares one M-cycle multiplier among N requesters with round-robin
// grants, a latency-matched tag pipeline and per-requester credit limits.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int W       = 4,
  parameter int N       = 4,
  parameter int M       = 2,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_scheduler_if.slave   bus,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_product,
  output logic              busy
);
  localparam int IDW = id_w(N);
  localparam int CW  = cnt_w(MAX_OUT);
  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;
  logic [N-1:0]   elig, grant;
  logic           grant_any;
  logic [IDW-1:0] g, ptr;
  logic [CW-1:0]  cnt [N];
  tag_t           out_tag;
  // Masking with rst_n keeps grants (and the M=0 response path) quiet during reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) elig[i] = rst_n && bus.req_valid[i] && (cnt[i] < CW'(MAX_OUT));
  end
  rr_arbiter #(.N(N)) u_arb (.elig(elig), .ptr(ptr), .grant(grant), .grant_any(grant_any), .grant_idx(g));
  assign bus.req_ready = grant;
  assign mul_a = grant_any ? bus.req_a[g] : '0;
  assign mul_b = grant_any ? bus.req_b[g] : '0;
  generate
    if (M == 0) begin : g_comb
      assign out_tag = '{valid: grant_any, id: g};
    end else begin : g_pipe
      tag_t tq [M];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < M; i++) tq[i] <= '0;
        else begin
          tq[0] <= '{valid: grant_any, id: g};
          for (int i = 1; i < M; i++) tq[i] <= tq[i-1];
        end
      assign out_tag = tq[M-1];
    end
  endgenerate
  assign bus.resp_valid   = out_tag.valid;
  assign bus.resp_id      = out_tag.id;
  assign bus.resp_product = out_tag.valid ? mul_product : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (grant_any) ptr <= (g == IDW'(N - 1)) ? '0 : g + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N; i++) cnt[i] <= '0;
    else for (int i = 0; i < N; i++)
      if (grant[i] != (out_tag.valid && out_tag.id == IDW'(i))) cnt[i] <= grant[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N; i++) busy = busy | (cnt[i] != '0);
  end
  generate
    for (genvar j = 0; j < N; j++) begin : g_chk
      assert property (@(posedge clk) disable iff (!rst_n) cnt[j] <= CW'(MAX_OUT));
      assert property (@(posedge clk) disable iff (!rst_n)
        (out_tag.valid && out_tag.id == IDW'(j)) |-> (cnt[j] != '0 || grant[j]));
    end
  endgenerate
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: vector table, directed corner sequences and a randomized run
// checked against a queue-based reference model.
module tb_mult_scheduler;
  localparam int W = 4, N = 4, MM = 2, MAXO = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mult_scheduler_if #(.W(W), .N(N)) bus ();
  mult_scheduler_if #(.W(W), .N(N)) bus0 ();
  logic [W-1:0] mul_a, mul_b, mul_a0, mul_b0;
  logic [2*W-1:0] mul_p, p1, p2, mul_p0;
  logic busy, busy0;
  mult_scheduler #(.W(W), .N(N), .M(MM), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_p), .busy(busy));
  mult_scheduler #(.W(W), .N(N), .M(0), .MAX_OUT(MAXO)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_product(mul_p0), .busy(busy0));
  always @(posedge clk) begin
    p1 <= 8'(mul_a) * 8'(mul_b);
    p2 <= p1;
  end
  assign mul_p  = p2;
  assign mul_p0 = 8'(mul_a0) * 8'(mul_b0);

  int n_chk = 0, n_fail = 0;
  typedef struct { int id; int a; int b; int prod; } vec_t;
  typedef struct { int due; int id; int prod; } pend_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic samp();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus0.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask
  task automatic single(input int id, input int a, input int b, input int prod);
    bus.req_valid = 4'(1 << id);
    bus.req_a[id] = 4'(a);
    bus.req_b[id] = 4'(b);
    samp();
    chk("single_ready", bus.req_ready, 1 << id);
    tick();
    bus.req_valid = '0;
    samp();
    chk("single_resp_early", bus.resp_valid, 0);
    chk("single_busy_t1", busy, 1);
    tick();
    samp();
    chk("single_resp_valid", bus.resp_valid, 1);
    chk("single_resp_id", bus.resp_id, id);
    chk("single_product", bus.resp_product, prod);
    chk("single_busy_t2", busy, 1);
    tick();
    samp();
    chk("single_busy_t3", busy, 0);
    chk("single_resp_done", bus.resp_valid, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rr_exp [6];
    logic [3:0] cs_exp [6];
    logic       cs_rv  [6];
    logic [3:0] sc_val [5];
    logic [3:0] sc_exp [5];
    pend_t q [$];
    int mcnt [N];
    int mptr, g, idx;
    logic rv, eb;
    vecs = '{'{1, 3, 5, 15}, '{3, 15, 15, 225}, '{0, 0, 9, 0},
             '{2, 15, 1, 15}, '{0, 12, 11, 132}, '{3, 7, 8, 56}};
    rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    cs_exp = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    cs_rv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    sc_val = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h4};
    sc_exp = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h0};
    bus.req_valid = 4'hF;
    bus.req_a = '{default: 4'h5};
    bus.req_b = '{default: 4'h5};
    bus0.req_valid = 4'hF;
    bus0.req_a = '{default: 4'h5};
    bus0.req_b = '{default: 4'h5};
    samp();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_product", bus.resp_product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_m0_resp_valid", bus0.resp_valid, 0);
    do_reset();
    foreach (vecs[v]) single(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].prod);

    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = 4'(i + 1);
      bus.req_b[i] = 4'd2;
    end
    for (int c = 0; c < 6; c++) begin
      samp();
      chk("rr_ready", bus.req_ready, rr_exp[c]);
      if (c >= MM) begin
        chk("rr_resp_valid", bus.resp_valid, 1);
        chk("rr_resp_id", bus.resp_id, c - MM);
        chk("rr_product", bus.resp_product, 2 * (c - MM + 1));
      end
      tick();
    end
    bus.req_valid = '0;
    repeat (4) tick();

    do_reset();
    bus.req_valid = 4'h1;
    bus.req_a[0] = 4'd2;
    bus.req_b[0] = 4'd3;
    for (int c = 0; c < 6; c++) begin
      samp();
      chk("credit_ready", bus.req_ready, cs_exp[c]);
      chk("credit_resp_valid", bus.resp_valid, cs_rv[c]);
      tick();
    end
    bus.req_valid = '0;
    repeat (4) tick();

    do_reset();
    bus.req_a[2] = 4'd4;
    bus.req_b[2] = 4'd4;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = sc_val[c];
      samp();
      chk("same_cycle_ready", bus.req_ready, sc_exp[c]);
      tick();
    end
    bus.req_valid = '0;
    samp();
    chk("same_cycle_resp_last", bus.resp_valid, 1);
    tick();
    samp();
    chk("same_cycle_busy_drained", busy, 0);
    tick();

    do_reset();
    bus.req_valid = 4'h3;
    samp();
    chk("midrst_ready0", bus.req_ready, 4'h1);
    tick();
    samp();
    chk("midrst_ready1", bus.req_ready, 4'h2);
    tick();
    rst_n = 1'b0;
    samp();
    chk("midrst_resp_in_reset", bus.resp_valid, 0);
    chk("midrst_busy_in_reset", busy, 0);
    chk("midrst_ready_in_reset", bus.req_ready, 0);
    tick();
    samp();
    chk("midrst_resp_in_reset2", bus.resp_valid, 0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'h5;
    samp();
    chk("midrst_ptr_zero", bus.req_ready, 4'h1);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_resp_after", bus.resp_valid, 0);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    single(3, 15, 15, 225);

    bus0.req_valid = 4'h1;
    bus0.req_a[0] = 4'd7;
    bus0.req_b[0] = 4'd9;
    samp();
    chk("m0_ready", bus0.req_ready, 4'h1);
    chk("m0_resp_valid", bus0.resp_valid, 1);
    chk("m0_resp_id", bus0.resp_id, 0);
    chk("m0_product", bus0.resp_product, 63);
    tick();
    bus0.req_valid = 4'h8;
    bus0.req_a[3] = 4'd2;
    bus0.req_b[3] = 4'd3;
    samp();
    chk("m0_resp_id3", bus0.resp_id, 3);
    chk("m0_product3", bus0.resp_product, 6);
    tick();
    bus0.req_valid = '0;
    samp();
    chk("m0_idle_resp", bus0.resp_valid, 0);
    chk("m0_idle_busy", busy0, 0);
    tick();

    do_reset();
    mptr = 0;
    foreach (mcnt[i]) mcnt[i] = 0;
    for (int c = 0; c < 300; c++) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_a[i] = 4'($urandom);
        bus.req_b[i] = 4'($urandom);
      end
      samp();
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && bus.req_valid[idx] && mcnt[idx] < MAXO) g = idx;
      end
      rv = (q.size() > 0) && (q[0].due == c);
      eb = 1'b0;
      foreach (mcnt[i]) if (mcnt[i] > 0) eb = 1'b1;
      chk("rnd_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
      chk("rnd_resp_valid", bus.resp_valid, rv);
      chk("rnd_busy", busy, eb);
      if (rv) begin
        chk("rnd_resp_id", bus.resp_id, q[0].id);
        chk("rnd_product", bus.resp_product, q[0].prod);
        mcnt[q[0].id]--;
        void'(q.pop_front());
      end else chk("rnd_product_idle", bus.resp_product, 0);
      if (g >= 0) begin
        mcnt[g]++;
        q.push_back('{c + MM, g, int'(bus.req_a[g]) * int'(bus.req_b[g])});
        mptr = (g + 1) % N;
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
